tof_thresh_capture: RTL and testbench

//  Avalon-MM slave that reads one ADC channel against the 24-bit threshold driven by the CHx_THRESH output PIO.
//  It timestamps the first sustained threshold crossing after an arm command, giving ultrasonic time-of-flight in samples.

---
 rtl/tof_thresh_capture.sv | 234 +++++++++++++++++++++++
 tb/tb_tof_thresh_capture.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tof_thresh_capture.sv
//------------------------------------------------------------------------------
// tof_thresh_capture
//
// Avalon-MM slave that compares one ADC channel against a live threshold.
// It timestamps the first sustained threshold crossing after an ARM command,
// which gives the ultrasonic time-of-flight in samples. Software arms the
// block, waits for the STATUS flags or irq, then reads TSTAMP and PEAK.
//
// Ports
//   clk          system clock
//   reset_n      asynchronous active-low reset
//   sample_data  ADC magnitude (unsigned)
//   sample_valid sample_data is valid this cycle
//   threshold    live compare threshold; it is not latched
//   address      register select: 0 CTRL, 1 STATUS, 2 TSTAMP, 3 PEAK
//   chipselect   slave select
//   write_n      active-low write strobe
//   writedata    write data
//   readdata     combinational read mux with zero wait states
//   irq          registered level interrupt, (capt|tout) & IRQ_EN
//------------------------------------------------------------------------------
`timescale 1ns/1ps
module tof_thresh_capture #(
    parameter int DATA_W        = 24,
    parameter int CNT_W         = 32,
    parameter int BLANK_SAMPLES = 64,
    parameter int MIN_HITS      = 3,
    parameter int TIMEOUT_SAMP  = 65535
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] sample_data,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] threshold,
    input  logic [1:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic              irq
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_ARMED = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int HIT_W = $clog2(MIN_HITS + 1);
    localparam logic [HIT_W-1:0] HIT_LAST   = HIT_W'(MIN_HITS - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_SAMPLES > 0) ? BLANK_SAMPLES - 1 : 0);
    localparam logic [CNT_W-1:0] TOUT_LAST  = CNT_W'(TIMEOUT_SAMP - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
    // With no blanking window the arm command goes straight to ARMED.
    localparam state_t ARM_TARGET = (BLANK_SAMPLES == 0) ? ST_ARMED : ST_BLANK;

    // Larger of the running peak and the current sample.
    function automatic logic [DATA_W-1:0] peak_max(input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b);
        peak_max = (a > b) ? a : b;
    endfunction

    state_t              state_r, state_nxt_s;
    logic [CNT_W-1:0]    counter_r, counter_nxt_s, counter_inc_s;
    logic [HIT_W-1:0]    hit_cnt_r, hit_cnt_nxt_s;
    logic [CNT_W-1:0]    tstamp_r, tstamp_nxt_s;
    logic [DATA_W-1:0]   peak_r, peak_nxt_s;
    logic                capt_flag_r, capt_flag_nxt_s;
    logic                tout_flag_r, tout_flag_nxt_s;
    logic                irq_en_r, irq_en_nxt_s;
    logic                irq_r;
    logic                capt_set_s, tout_set_s, clear_all_s;

    logic write_s, ctrl_wr_s, stat_wr_s;
    logic arm_s, abort_s, clr_capt_s, clr_tout_s, hit_s;
    logic unused_wdata_s;

    assign write_s    = chipselect & ~write_n;
    assign ctrl_wr_s  = write_s & (address == 2'd0);
    assign stat_wr_s  = write_s & (address == 2'd1);
    assign arm_s      = ctrl_wr_s & writedata[0];
    assign abort_s    = ctrl_wr_s & writedata[2];
    assign clr_capt_s = stat_wr_s & writedata[2];
    assign clr_tout_s = stat_wr_s & writedata[3];
    assign hit_s      = sample_valid & (sample_data >= threshold);
    assign unused_wdata_s = ^writedata[31:4];

    // Counter saturates at all-ones instead of wrapping.
    assign counter_inc_s = (counter_r == CNT_MAX) ? counter_r : counter_r + CNT_W'(1);

    // Next-state and next-data logic; ABORT beats ARM, ARM beats the sequencer.
    always_comb begin
        state_nxt_s   = state_r;
        counter_nxt_s = counter_r;
        hit_cnt_nxt_s = hit_cnt_r;
        tstamp_nxt_s  = tstamp_r;
        peak_nxt_s    = peak_r;
        capt_set_s    = 1'b0;
        tout_set_s    = 1'b0;
        clear_all_s   = 1'b0;

        if (abort_s) begin
            state_nxt_s = ST_IDLE;
        end else if (arm_s) begin
            state_nxt_s   = ARM_TARGET;
            counter_nxt_s = {CNT_W{1'b0}};
            hit_cnt_nxt_s = {HIT_W{1'b0}};
            tstamp_nxt_s  = {CNT_W{1'b0}};
            peak_nxt_s    = {DATA_W{1'b0}};
            clear_all_s   = 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_nxt_s = ST_IDLE;
                end
                ST_BLANK: begin
                    if (sample_valid) begin
                        counter_nxt_s = counter_inc_s;
                        if (counter_r == BLANK_LAST) begin
                            state_nxt_s = ST_ARMED;
                        end else begin
                            state_nxt_s = ST_BLANK;
                        end
                    end else begin
                        state_nxt_s = ST_BLANK;
                    end
                end
                ST_ARMED: begin
                    if (sample_valid) begin
                        counter_nxt_s = counter_inc_s;
                        if (hit_s) begin
                            hit_cnt_nxt_s = hit_cnt_r + HIT_W'(1);
                            if (hit_cnt_r == {HIT_W{1'b0}}) begin
                                tstamp_nxt_s = counter_r;
                                peak_nxt_s   = sample_data;
                            end else begin
                                peak_nxt_s   = peak_max(peak_r, sample_data);
                            end
                        end else begin
                            hit_cnt_nxt_s = {HIT_W{1'b0}};
                            peak_nxt_s    = {DATA_W{1'b0}};
                        end
                        // A capture on the last allowed sample takes priority over timeout.
                        if (hit_s && (hit_cnt_r == HIT_LAST)) begin
                            state_nxt_s = ST_DONE;
                            capt_set_s  = 1'b1;
                        end else if (counter_r == TOUT_LAST) begin
                            state_nxt_s = ST_DONE;
                            tout_set_s  = 1'b1;
                        end else begin
                            state_nxt_s = ST_ARMED;
                        end
                    end else begin
                        state_nxt_s = ST_ARMED;
                    end
                end
                ST_DONE: begin
                    state_nxt_s = ST_DONE;
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end
    end

    // Flag and IRQ_EN next values; a set in the same cycle as a clear wins.
    always_comb begin
        capt_flag_nxt_s = capt_flag_r;
        tout_flag_nxt_s = tout_flag_r;
        irq_en_nxt_s    = irq_en_r;
        if (capt_set_s) begin
            capt_flag_nxt_s = 1'b1;
        end else if (clear_all_s || clr_capt_s) begin
            capt_flag_nxt_s = 1'b0;
        end else begin
            capt_flag_nxt_s = capt_flag_r;
        end
        if (tout_set_s) begin
            tout_flag_nxt_s = 1'b1;
        end else if (clear_all_s || clr_tout_s) begin
            tout_flag_nxt_s = 1'b0;
        end else begin
            tout_flag_nxt_s = tout_flag_r;
        end
        if (ctrl_wr_s) begin
            irq_en_nxt_s = writedata[1];
        end else begin
            irq_en_nxt_s = irq_en_r;
        end
    end

    // State, data and flag registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= ST_IDLE;
            counter_r   <= {CNT_W{1'b0}};
            hit_cnt_r   <= {HIT_W{1'b0}};
            tstamp_r    <= {CNT_W{1'b0}};
            peak_r      <= {DATA_W{1'b0}};
            capt_flag_r <= 1'b0;
            tout_flag_r <= 1'b0;
            irq_en_r    <= 1'b0;
            irq_r       <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            counter_r   <= counter_nxt_s;
            hit_cnt_r   <= hit_cnt_nxt_s;
            tstamp_r    <= tstamp_nxt_s;
            peak_r      <= peak_nxt_s;
            capt_flag_r <= capt_flag_nxt_s;
            tout_flag_r <= tout_flag_nxt_s;
            irq_en_r    <= irq_en_nxt_s;
            // irq follows the flags one cycle after they change.
            irq_r       <= irq_en_r & (capt_flag_r | tout_flag_r);
        end
    end

    assign irq = irq_r;

    // Zero-wait-state read mux.
    always_comb begin
        readdata = 32'd0;
        case (address)
            2'd0:    readdata = {30'd0, irq_en_r, 1'b0};
            2'd1:    readdata = {28'd0, tout_flag_r, capt_flag_r, state_r};
            2'd2:    readdata = 32'(tstamp_r);
            2'd3:    readdata = 32'(peak_r);
            default: readdata = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_tof_thresh_capture.sv
`timescale 1ns/1ps
module tb_tof_thresh_capture;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [23:0] sample_data;
    logic        sample_valid;
    logic [23:0] threshold;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    always #5 clk = ~clk;

    tof_thresh_capture dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .sample_data  (sample_data),
        .sample_valid (sample_valid),
        .threshold    (threshold),
        .address      (address),
        .chipselect   (chipselect),
        .write_n      (write_n),
        .writedata    (writedata),
        .readdata     (readdata),
        .irq          (irq)
    );

    typedef struct {
        string       name;
        logic [31:0] exp;
        bit          is_irq;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    logic chk_req  = 1'b0;

    // Monitor: whenever the stimulus presents an observation window, pop and compare.
    always @(negedge clk) begin
        exp_t        e;
        logic [31:0] act;
        if (chk_req) begin
            n_checks++;
            if (sb_q.size() == 0) begin
                n_errors++;
                $display("FAIL sb_empty: got an observation with no expected value queued");
            end else begin
                e   = sb_q.pop_front();
                act = e.is_irq ? {31'd0, irq} : readdata;
                if (act !== e.exp) begin
                    n_errors++;
                    $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, act, e.exp);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'd0;
    endtask

    task automatic rd(input string nm, input logic [1:0] a, input logic [31:0] e);
        exp_t x;
        x.name = nm; x.exp = e; x.is_irq = 1'b0;
        sb_q.push_back(x);
        address    = a;
        chipselect = 1'b1;
        chk_req    = 1'b1;
        tick();
        chk_req    = 1'b0;
        chipselect = 1'b0;
    endtask

    task automatic chk_irq(input string nm, input logic e);
        exp_t x;
        x.name = nm; x.exp = {31'd0, e}; x.is_irq = 1'b1;
        sb_q.push_back(x);
        chk_req = 1'b1;
        tick();
        chk_req = 1'b0;
    endtask

    task automatic smp(input logic v, input logic [23:0] d);
        sample_valid = v;
        sample_data  = d;
        tick();
        sample_valid = 1'b0;
        sample_data  = 24'd0;
    endtask

    task automatic zeros(input int n);
        for (int i = 0; i < n; i++) smp(1'b1, 24'd0);
    endtask

    // Bound on total run time.
    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        reset_n      = 1'b0;
        sample_data  = 24'd0;
        sample_valid = 1'b0;
        threshold    = 24'd1000;
        address      = 2'd0;
        chipselect   = 1'b0;
        write_n      = 1'b1;
        writedata    = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        tick();

        // Reset state
        rd("rst_ctrl",   2'd0, 32'd0);
        rd("rst_status", 2'd1, 32'd0);
        rd("rst_tstamp", 2'd2, 32'd0);
        rd("rst_peak",   2'd3, 32'd0);
        chk_irq("rst_irq", 1'b0);

        // Basic capture: hits at 200..202
        wr(2'd0, 32'd1);
        zeros(200);
        smp(1'b1, 24'd1200);
        smp(1'b1, 24'd1500);
        rd("t1_two_hits_status", 2'd1, 32'd2);
        smp(1'b1, 24'd1100);
        rd("t1_status", 2'd1, 32'd7);
        rd("t1_tstamp", 2'd2, 32'd200);
        rd("t1_peak",   2'd3, 32'd1500);
        chk_irq("t1_irq_gated", 1'b0);

        // Broken burst then real burst at 300..302 (302 equals threshold)
        wr(2'd0, 32'd1);
        rd("t2_arm_status", 2'd1, 32'd1);
        rd("t2_arm_tstamp", 2'd2, 32'd0);
        zeros(200);
        smp(1'b1, 24'd2000);
        smp(1'b1, 24'd2500);
        smp(1'b1, 24'd0);
        zeros(97);
        smp(1'b1, 24'd1100);
        smp(1'b1, 24'd1300);
        smp(1'b1, 24'd1000);
        rd("t2_status", 2'd1, 32'd7);
        rd("t2_tstamp", 2'd2, 32'd300);
        rd("t2_peak",   2'd3, 32'd1300);

        // Hit inside blanking window, then silence until timeout
        wr(2'd0, 32'd1);
        zeros(10);
        smp(1'b1, 24'd5000);
        zeros(65534 - 11);
        rd("t3_pre_tout_status", 2'd1, 32'd2);
        smp(1'b1, 24'd0);
        rd("t3_tout_status", 2'd1, 32'hB);
        rd("t3_tstamp", 2'd2, 32'd0);
        rd("t3_peak",   2'd3, 32'd0);
        wr(2'd1, 32'h8);
        rd("t3_clr_tout", 2'd1, 32'd3);

        // IRQ enable, capture, flag clear, re-arm restart
        wr(2'd0, 32'd2);
        rd("t4_ctrl", 2'd0, 32'd2);
        wr(2'd0, 32'd3);
        zeros(64);
        smp(1'b1, 24'd1200);
        smp(1'b1, 24'd1200);
        smp(1'b1, 24'd1200);
        rd("t4_status", 2'd1, 32'd7);
        chk_irq("t4_irq_set", 1'b1);
        wr(2'd1, 32'h4);
        rd("t4_clr_status", 2'd1, 32'd3);
        chk_irq("t4_irq_clr", 1'b0);
        rd("t4_tstamp", 2'd2, 32'd64);
        wr(2'd0, 32'd3);
        zeros(74);
        rd("t4_mid_armed", 2'd1, 32'd2);
        wr(2'd0, 32'd3);
        rd("t4_rearm_status", 2'd1, 32'd1);
        zeros(64);
        smp(1'b1, 24'd1200);
        smp(1'b1, 24'd1200);
        smp(1'b1, 24'd1200);
        rd("t4_rearm_tstamp", 2'd2, 32'd64);

        // sample_valid toggling, invalid cycles hold everything
        wr(2'd0, 32'd1);
        for (int i = 0; i < 64; i++) begin
            smp(1'b1, 24'd0);
            smp(1'b0, 24'd0);
        end
        smp(1'b1, 24'd1200);
        smp(1'b0, 24'd9999);
        smp(1'b1, 24'd1300);
        smp(1'b0, 24'd0);
        rd("t5_two_hits", 2'd1, 32'd2);
        smp(1'b1, 24'd1250);
        rd("t5_status", 2'd1, 32'd7);
        rd("t5_tstamp", 2'd2, 32'd64);
        rd("t5_peak",   2'd3, 32'd1300);
        chk_irq("t5_irq_off", 1'b0);

        // ABORT from DONE keeps data and flags
        wr(2'd0, 32'd2);
        rd("t6_ctrl", 2'd0, 32'd2);
        chk_irq("t6_irq_on", 1'b1);
        wr(2'd0, 32'd4);
        rd("t6_abort_status", 2'd1, 32'd4);
        rd("t6_abort_tstamp", 2'd2, 32'd64);
        rd("t6_abort_peak",   2'd3, 32'd1300);

        // Async reset while ARMED
        wr(2'd0, 32'd3);
        zeros(64);
        smp(1'b1, 24'd1500);
        rd("t7_armed", 2'd1, 32'd2);
        reset_n = 1'b0;
        rd("t7_rst_status", 2'd1, 32'd0);
        rd("t7_rst_tstamp", 2'd2, 32'd0);
        rd("t7_rst_peak",   2'd3, 32'd0);
        rd("t7_rst_ctrl",   2'd0, 32'd0);
        chk_irq("t7_rst_irq", 1'b0);
        reset_n = 1'b1;
        tick();

        // ARM + ABORT in one write while blanking
        wr(2'd0, 32'd1);
        zeros(5);
        rd("t8_blank", 2'd1, 32'd1);
        wr(2'd0, 32'd5);
        rd("t8_arm_abort", 2'd1, 32'd0);

        tick();
        if (sb_q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL sb_drain: got %0d entries left expected 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
